// File: rtl/mult_booth_seq_if.sv
// rtl/mult_booth_seq_if.sv - start/fim multiply handshake between the control unit and the Booth multiplier.
interface mult_booth_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             fim;
  logic             busy;

  modport master (
    output start, a, b,
    input  hi, lo, fim, busy
  );

  modport slave (
    input  start, a, b,
    output hi, lo, fim, busy
  );
endinterface

// File: rtl/mult_booth_seq.sv
// rtl/mult_booth_seq.sv - sequential radix-2 Booth signed multiplier, one step per clock.
// Optional MULT_BOOTH_EARLY_EXIT_EN: zero operands finish after a single cycle with a zero product.
module mult_booth_seq #(
  parameter int WIDTH = 32
) (
  input logic             clock,
  input logic             reset,
  mult_booth_seq_if.slave bus
);
  localparam int              CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH:0]       r_acc;
  logic [WIDTH:0]       r_m;
  logic [WIDTH-1:0]     r_q;
  logic                 r_qm1;
  logic [CW-1:0]        r_count;
  logic                 r_zero;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic                 r_fim;
  logic                 r_busy;

  logic [WIDTH:0]       w_addsub;
  logic [2*WIDTH+1:0]   w_cat;
  logic [2*WIDTH+1:0]   w_shift;
  logic                 w_accept;
  logic                 w_zero;
  logic                 w_last;

  assign w_accept = (r_state == S_IDLE) && bus.start;

`ifdef MULT_BOOTH_EARLY_EXIT_EN
  assign w_zero = (bus.a == '0) || (bus.b == '0);
`else
  assign w_zero = 1'b0;
`endif

  // A zero-operand job spends one RUN cycle so fim still lands one edge after acceptance.
  assign w_last = (r_count == LAST) || r_zero;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_next = S_RUN;
      S_RUN:   if (w_last)   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_addsub = r_acc;
    unique case ({r_q[0], r_qm1})
      2'b01:   w_addsub = r_acc + r_m;
      2'b10:   w_addsub = r_acc - r_m;
      default: w_addsub = r_acc;
    endcase
    w_cat   = {w_addsub, r_q, r_qm1};
    w_shift = {w_addsub[WIDTH], w_cat[2*WIDTH+1:1]};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_acc   <= '0;
      r_m     <= '0;
      r_q     <= '0;
      r_qm1   <= 1'b0;
      r_count <= '0;
      r_zero  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_fim   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_fim  <= (w_next == S_DONE);
      r_busy <= (w_next != S_IDLE);
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_m     <= {bus.a[WIDTH-1], bus.a};
            r_q     <= bus.b;
            r_acc   <= '0;
            r_qm1   <= 1'b0;
            r_count <= '0;
            r_zero  <= w_zero;
          end
        end
        S_RUN: begin
          r_acc   <= w_shift[2*WIDTH+1:WIDTH+1];
          r_q     <= w_shift[WIDTH:1];
          r_qm1   <= w_shift[0];
          r_count <= r_count + CW'(1);
          if (w_last) begin
            r_hi <= r_zero ? '0 : w_shift[2*WIDTH:WIDTH+1];
            r_lo <= r_zero ? '0 : w_shift[WIDTH:1];
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;
  assign bus.fim  = r_fim;
  assign bus.busy = r_busy;
endmodule

// File: tb/tb_mult_booth_seq.sv
// tb/tb_mult_booth_seq.sv - randomized and directed checks of mult_booth_seq against a product/latency model.
module tb_mult_booth_seq;
  localparam int W = 32;
`ifdef MULT_BOOTH_EARLY_EXIT_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = W;
`endif

  logic clock;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  mult_booth_seq_if #(.WIDTH(W)) bus ();

  mult_booth_seq #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: product by plain signed multiply, completion after a fixed latency.
  logic                  m_busy = 1'b0;
  logic                  m_fim  = 1'b0;
  logic [W-1:0]          m_hi   = '0;
  logic [W-1:0]          m_lo   = '0;
  int                    m_left = 0;
  logic signed [2*W-1:0] m_prod, sa, sb;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_busy = 1'b0; m_fim = 1'b0; m_hi = '0; m_lo = '0; m_left = 0;
    end else if (m_fim) begin
      m_fim = 1'b0; m_busy = 1'b0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_fim = 1'b1;
        {m_hi, m_lo} = m_prod;
      end
    end else if (bus.start) begin
      sa = $signed(bus.a);
      sb = $signed(bus.b);
      m_prod = sa * sb;
      m_busy = 1'b1;
      m_left = (bus.a == '0 || bus.b == '0) ? ZLAT : W;
    end
  end

  always @(negedge clock) begin
    chk("model_hi",   bus.hi,   m_hi);
    chk("model_lo",   bus.lo,   m_lo);
    chk("model_fim",  bus.fim,  m_fim);
    chk("model_busy", bus.busy, m_busy);
  end

  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo,
                        input int elat, input string nm);
    int cyc;
    int bcnt;
    @(posedge clock); #1;
    bus.start = 1'b1; bus.a = ia; bus.b = ib;
    @(posedge clock); #1;
    bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom;
    cyc = 0; bcnt = 0;
    @(negedge clock);
    if (bus.busy) bcnt++;
    while (cyc < 200) begin
      @(posedge clock);
      cyc++;
      @(negedge clock);
      if (bus.busy) bcnt++;
      if (bus.fim) break;
    end
    chk({nm, "_latency"}, cyc, elat);
    chk({nm, "_hi"}, bus.hi, ehi);
    chk({nm, "_lo"}, bus.lo, elo);
    chk({nm, "_busy_cycles"}, bcnt, elat + 1);
    @(negedge clock);
    chk({nm, "_fim_width"}, bus.fim, 1'b0);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return 32'h7FFF_FFFF;
      3:       return '1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int nfim, t1, t2;
    logic [W-1:0] cap_hi, cap_lo;
    bus.start = 1'b0; bus.a = '0; bus.b = '0;
    reset = 1'b0;
    #1 reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("reset_hi", bus.hi, '0);
    chk("reset_lo", bus.lo, '0);
    chk("reset_fim", bus.fim, 1'b0);
    chk("reset_busy", bus.busy, 1'b0);

    run_op(32'd7, 32'd6, 32'h0, 32'h2A, W, "7x6");
    run_op(32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, W, "m3x5");
    run_op(32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, W, "minxmin");
    run_op(32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, W, "maxxmin");
    run_op(32'd0, 32'd12345, 32'h0, 32'h0, ZLAT, "zero_a");

    // Re-pulsed start with new operands in the middle of a job must be ignored.
    @(posedge clock); #1;
    bus.start = 1'b1; bus.a = 32'd100; bus.b = 32'hFFFF_FFFD;
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clock);
    #1 bus.start = 1'b1; bus.a = 32'd5; bus.b = 32'd5;
    @(posedge clock); #1 bus.start = 1'b0;
    nfim = 0; cap_hi = '0; cap_lo = '0;
    for (int i = 0; i < W + 20; i++) begin
      @(negedge clock);
      if (bus.fim) begin
        nfim++; cap_hi = bus.hi; cap_lo = bus.lo;
      end
    end
    chk("interfere_fim_count", nfim, 1);
    chk("interfere_hi", cap_hi, 32'hFFFF_FFFF);
    chk("interfere_lo", cap_lo, 32'hFFFF_FED4);

    // Asynchronous reset in the middle of RUN, applied away from the clock edge.
    @(posedge clock); #1;
    bus.start = 1'b1; bus.a = 32'd9; bus.b = 32'd9;
    @(posedge clock); #1 bus.start = 1'b0;
    repeat (15) @(posedge clock);
    @(negedge clock); #2;
    reset = 1'b1;
    #1;
    chk("midrst_hi", bus.hi, '0);
    chk("midrst_lo", bus.lo, '0);
    chk("midrst_fim", bus.fim, 1'b0);
    chk("midrst_busy", bus.busy, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    run_op(32'd2, 32'd3, 32'h0, 32'h6, W, "after_rst");

    // Held start: back-to-back completions are W+2 cycles apart.
    @(posedge clock); #1;
    bus.start = 1'b1; bus.a = 32'd3; bus.b = 32'd4;
    t1 = -1; t2 = -1;
    for (int i = 0; i < 3 * (W + 2) + 4; i++) begin
      @(negedge clock);
      if (bus.fim) begin
        if (t1 < 0) t1 = i;
        else if (t2 < 0) t2 = i;
      end
    end
    chk("b2b_first", t1, W + 1);
    chk("b2b_gap", t2 - t1, W + 2);
    chk("b2b_lo", bus.lo, 32'd12);
    @(posedge clock); #1 bus.start = 1'b0;
    repeat (W + 5) @(posedge clock);

    for (int n = 0; n < 40; n++) begin
      @(posedge clock); #1;
      bus.start = 1'b1; bus.a = pick(); bus.b = pick();
      repeat ($urandom_range(1, 40)) begin
        @(posedge clock); #1;
        if ($urandom_range(0, 3) == 0) begin
          bus.a = pick(); bus.b = pick();
        end
      end
      bus.start = 1'b0;
      repeat ($urandom_range(0, 5)) @(posedge clock);
    end
    repeat (2 * W + 4) @(posedge clock);
    @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
